fir_shift_reg: RTL and testbench

- Single-port synchronous RAM that holds the FIR delay line (tap history) for the fir datapath.
- Provides 11 words of 32 bits by default, with one read/write port and a registered read output.
- The FIR controller shifts samples through it, one read and one write per access cycle.

---
 rtl/fir_shift_reg.sv | 53 +++++
 tb/tb_fir_shift_reg.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fir_shift_reg.sv
// rtl/fir_shift_reg.sv - FIR tap-history RAM with one read-first port and a registered read output
module fir_shift_reg #(
  parameter int DataWidth    = 32,
  parameter int AddressRange = 11,
  parameter int AddressWidth = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [AddressWidth-1:0] address0,
  input  logic                    ce0,
  input  logic                    we0,
  input  logic [DataWidth-1:0]    d0,
  output logic [DataWidth-1:0]    q0
);

  logic [DataWidth-1:0] mem_q [AddressRange];
  logic [DataWidth-1:0] mem_d [AddressRange];
  logic [DataWidth-1:0] q0_q;
  logic [DataWidth-1:0] q0_d;

  // An address that matches no word reads as zero and writes nowhere, so
  // out-of-range accesses can never alias onto a real tap.
  always_comb begin
    mem_d = mem_q;
    q0_d  = q0_q;
    if (ce0) begin
      q0_d = '0;
      for (int i = 0; i < AddressRange; i++) begin
        if (address0 == AddressWidth'(i)) begin
          q0_d = mem_q[i];
          if (we0) begin
            mem_d[i] = d0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q0_q <= '0;
      for (int i = 0; i < AddressRange; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      q0_q  <= q0_d;
      mem_q <= mem_d;
    end
  end

  assign q0 = q0_q;

endmodule

// File: tb/tb_fir_shift_reg.sv
// tb/tb_fir_shift_reg.sv - directed self-checking bench for fir_shift_reg
module tb_fir_shift_reg;

  logic        clk;
  logic        reset;
  logic [3:0]  address0;
  logic        ce0;
  logic        we0;
  logic [31:0] d0;
  logic [31:0] q0;

  int n_cmp;
  int n_bad;

  fir_shift_reg #(
    .DataWidth   (32),
    .AddressRange(11),
    .AddressWidth(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .address0(address0),
    .ce0     (ce0),
    .we0     (we0),
    .d0      (d0),
    .q0      (q0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; q0 is sampled on the falling edge after the access.
  task automatic do_read(input logic [3:0] a, output logic [31:0] data);
    @(negedge clk);
    address0 = a;
    ce0      = 1'b1;
    we0      = 1'b0;
    @(negedge clk);
    ce0  = 1'b0;
    data = q0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, output logic [31:0] old);
    @(negedge clk);
    address0 = a;
    d0       = d;
    ce0      = 1'b1;
    we0      = 1'b1;
    @(negedge clk);
    ce0 = 1'b0;
    we0 = 1'b0;
    old = q0;
  endtask

  logic [31:0] rd;
  logic [31:0] held;
  logic [31:0] shadow [11];

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    reset    = 1'b0;
    address0 = '0;
    ce0      = 1'b0;
    we0      = 1'b0;
    d0       = '0;
    #1;
    check_val("reset_q0_initial", q0, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Make q0 and storage non-zero, then reset between edges.
    do_write(4'd4, 32'hCAFE_0004, rd);
    do_read(4'd4, rd);
    check_val("pre_reset_read", rd, 32'hCAFE_0004);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_val("async_reset_q0", q0, 32'h0);
    // Reset held across an edge with a write pending: the write is discarded.
    address0 = 4'd2;
    d0       = 32'hFFFF_FFFF;
    ce0      = 1'b1;
    we0      = 1'b1;
    @(posedge clk);
    #1;
    check_val("reset_priority_q0", q0, 32'h0);
    ce0 = 1'b0;
    we0 = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b1;
    for (int a = 0; a <= 10; a++) begin
      do_read(4'(a), rd);
      check_val($sformatf("reset_mem[%0d]", a), rd, 32'h0);
    end

    // Fill and read back every word.
    for (int a = 0; a <= 10; a++) begin
      do_write(4'(a), 32'h1000_0000 + 32'(a), rd);
      check_val($sformatf("fill_old[%0d]", a), rd, 32'h0);
    end
    for (int a = 0; a <= 10; a++) begin
      do_read(4'(a), rd);
      check_val($sformatf("fill_read[%0d]", a), rd, 32'h1000_0000 + 32'(a));
    end
    repeat (3) @(negedge clk);
    check_val("q0_hold_ce0_low", q0, 32'h1000_000A);

    // Read-first behaviour.
    do_write(4'd5, 32'hAAAA_AAAA, rd);
    do_write(4'd5, 32'h5555_5555, rd);
    check_val("read_first_old", rd, 32'hAAAA_AAAA);
    do_read(4'd5, rd);
    check_val("read_first_new", rd, 32'h5555_5555);

    // Back-to-back reads with no idle cycle.
    @(negedge clk);
    address0 = 4'd0; ce0 = 1'b1; we0 = 1'b0;
    @(negedge clk);
    check_val("b2b_read0", q0, 32'h1000_0000);
    address0 = 4'd1;
    @(negedge clk);
    check_val("b2b_read1", q0, 32'h1000_0001);
    ce0 = 1'b0;

    // Enable gating: write enable alone must do nothing.
    held = q0;
    @(negedge clk);
    address0 = 4'd3; we0 = 1'b1; d0 = 32'hDEAD_BEEF; ce0 = 1'b0;
    repeat (4) @(negedge clk);
    check_val("gate_q0_hold", q0, held);
    we0 = 1'b0;
    do_read(4'd3, rd);
    check_val("gate_mem3", rd, 32'h1000_0003);

    // Out-of-range: write ignored, read returns zero, no aliasing.
    do_write(4'd12, 32'h1234_5678, rd);
    check_val("oor_write_q0", rd, 32'h0);
    do_read(4'd1, rd);
    do_read(4'd12, rd);
    check_val("oor_read12", rd, 32'h0);
    do_read(4'd15, rd);
    check_val("oor_read15", rd, 32'h0);
    for (int a = 0; a <= 10; a++) begin
      do_read(4'(a), rd);
      check_val($sformatf("oor_noalias[%0d]", a), rd,
                (a == 5) ? 32'h5555_5555 : 32'h1000_0000 + 32'(a));
    end

    // FIR shift: x_a = 0xA0A0_0000 + a, shift by one and insert 0x77.
    for (int a = 0; a <= 10; a++) begin
      shadow[a] = 32'hA0A0_0000 + 32'(a);
      do_write(4'(a), shadow[a], rd);
    end
    for (int i = 10; i >= 1; i--) begin
      do_read(4'(i - 1), rd);
      do_write(4'(i), rd, held);
    end
    do_write(4'd0, 32'h77, rd);
    for (int a = 0; a <= 10; a++) begin
      do_read(4'(a), rd);
      check_val($sformatf("shift[%0d]", a), rd,
                (a == 0) ? 32'h77 : 32'hA0A0_0000 + 32'(a - 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
